// File: rtl/dso_capture_buf.sv
// Triggered circular capture buffer: streams samples into a ring RAM, freezes it around a trigger.
// Read latency 1 (2 with OUTPUT_REG); no backpressure, reads honoured only once the record is DONE.
module dso_capture_buf #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 10,
   parameter int OUTPUT_REG = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic [ADDR_WIDTH-1:0] pre_depth,
   input  logic                  trig,
   input  logic                  force_trig,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  armed,
   output logic                  triggered,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] trig_ptr
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

   state_t                state;
   logic [2:0]            stat;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] pre_q;
   logic [ADDR_WIDTH-1:0] start_ptr;
   logic [ADDR_WIDTH:0]   cnt;
   logic [ADDR_WIDTH:0]   cnt_inc;
   logic [ADDR_WIDTH:0]   post_len;
   logic                  wr_en;
   logic                  rd_fire;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] ram_q;
   logic                  ram_vld;

   // {armed, triggered, done} for a given state; registered together with the state
   function automatic logic [2:0] flags(input state_t s);
      return {(s == PRE) || (s == WAIT_TRIG), (s == POST) || (s == DONE), s == DONE};
   endfunction

   assign wr_en    = wr_valid && ((state == PRE) || (state == WAIT_TRIG) || (state == POST));
   assign rd_fire  = rd_en && (state == DONE);
   assign cnt_inc  = cnt + CNT_ONE;
   assign post_len = DEPTH_W - {1'b0, pre_q};
   assign {armed, triggered, done} = stat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         stat      <= '0;
         wr_ptr    <= '0;
         cnt       <= '0;
         pre_q     <= '0;
         start_ptr <= '0;
         trig_ptr  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (arm) begin
            pre_q <= pre_depth;
            cnt   <= '0;
            if (pre_depth != '0) begin
               state <= PRE;
               stat  <= flags(PRE);
            end else begin
               state <= WAIT_TRIG;
               stat  <= flags(WAIT_TRIG);
            end
         end else if (wr_valid) begin
            case (state)
               PRE: begin
                  cnt <= cnt_inc;
                  if (cnt_inc == {1'b0, pre_q}) begin
                     state <= WAIT_TRIG;
                     stat  <= flags(WAIT_TRIG);
                  end
               end
               WAIT_TRIG: begin
                  if (trig || force_trig) begin
                     trig_ptr  <= wr_ptr;
                     start_ptr <= wr_ptr - pre_q;
                     cnt       <= CNT_ONE;
                     // with pre_q = DEPTH-1 the trigger sample alone completes the record
                     if (post_len == CNT_ONE) begin
                        state <= DONE;
                        stat  <= flags(DONE);
                     end else begin
                        state <= POST;
                        stat  <= flags(POST);
                     end
                  end
               end
               POST: begin
                  cnt <= cnt_inc;
                  if (cnt_inc == post_len) begin
                     state <= DONE;
                     stat  <= flags(DONE);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   // logical index is rebased onto the oldest pre-trigger sample
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_q   <= '0;
         ram_vld <= 1'b0;
      end else begin
         ram_vld <= rd_fire;
         if (rd_fire)
            ram_q <= mem[start_ptr + rd_addr];
      end
   end

   if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_q;
      logic                  out_vld;
      always_ff @(posedge clk) begin
         if (rst) begin
            out_q   <= '0;
            out_vld <= 1'b0;
         end else begin
            out_vld <= ram_vld;
            if (ram_vld)
               out_q <= ram_q;
         end
      end
      assign rd_data  = out_q;
      assign rd_valid = out_vld;
   end else begin : g_noreg
      assign rd_data  = ram_q;
      assign rd_valid = ram_vld;
   end
endmodule

// File: tb/tb_dso_capture_buf.sv
// Bench for dso_capture_buf: two instances (OUTPUT_REG 0 and 1) share stimulus; reads are scoreboarded.
module tb_dso_capture_buf;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arm = 1'b0;
   logic [9:0]  pre_depth = '0;
   logic        trig = 1'b0;
   logic        force_trig = 1'b0;
   logic [11:0] wr_data = '0;
   logic        wr_valid = 1'b0;
   logic        rd_en = 1'b0;
   logic [9:0]  rd_addr = '0;

   logic [11:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1;
   logic        armed0, armed1, triggered0, triggered1, done0, done1;
   logic [9:0]  trig_ptr0, trig_ptr1;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   typedef struct {int dat; int due;} exp_t;
   typedef struct {int scen; int addr; int dat;} rvec_t;
   exp_t  q0[$];
   exp_t  q1[$];
   rvec_t tbl[$];

   dso_capture_buf #(.DATA_WIDTH(12), .ADDR_WIDTH(10), .OUTPUT_REG(0)) u0 (
      .clk(clk), .rst(rst), .arm(arm), .pre_depth(pre_depth), .trig(trig),
      .force_trig(force_trig), .wr_data(wr_data), .wr_valid(wr_valid),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .armed(armed0), .triggered(triggered0), .done(done0), .trig_ptr(trig_ptr0));

   dso_capture_buf #(.DATA_WIDTH(12), .ADDR_WIDTH(10), .OUTPUT_REG(1)) u1 (
      .clk(clk), .rst(rst), .arm(arm), .pre_depth(pre_depth), .trig(trig),
      .force_trig(force_trig), .wr_data(wr_data), .wr_valid(wr_valid),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .armed(armed1), .triggered(triggered1), .done(done1), .trig_ptr(trig_ptr1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_stat(input string nm, input logic a, input logic t, input logic d);
      check({nm, "_oreg0"}, {29'd0, armed0, triggered0, done0}, {29'd0, a, t, d});
      check({nm, "_oreg1"}, {29'd0, armed1, triggered1, done1}, {29'd0, a, t, d});
   endtask

   // read results: pop the scoreboard, compare data and arrival cycle
   always @(negedge clk) begin
      exp_t e;
      if (rd_valid0) begin
         if (q0.size() == 0) check("unexpected_rd_valid_oreg0", 1, 0);
         else begin
            e = q0.pop_front();
            check("rd_data_oreg0", rd_data0, e.dat);
            check("rd_latency_oreg0", cyc, e.due);
         end
      end
      if (rd_valid1) begin
         if (q1.size() == 0) check("unexpected_rd_valid_oreg1", 1, 0);
         else begin
            e = q1.pop_front();
            check("rd_data_oreg1", rd_data1, e.dat);
            check("rd_latency_oreg1", cyc, e.due);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input logic t, input logic f, input logic v);
      wr_data = d[11:0]; trig = t; force_trig = f; wr_valid = v;
      tick();
      wr_valid = 1'b0; trig = 1'b0; force_trig = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; arm = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic do_arm(input int p);
      arm = 1'b1; pre_depth = p[9:0];
      tick();
      arm = 1'b0;
   endtask

   task automatic issue_read(input int a, input int d);
      rd_en = 1'b1; rd_addr = a[9:0];
      q0.push_back('{d, cyc + 1});
      q1.push_back('{d, cyc + 2});
      tick();
      rd_en = 1'b0;
   endtask

   task automatic drain(input string nm);
      repeat (4) tick();
      check({nm, "_drained_oreg0"}, q0.size(), 0);
      check({nm, "_drained_oreg1"}, q1.size(), 0);
   endtask

   task automatic apply(input int scen, input string nm);
      foreach (tbl[i])
         if (tbl[i].scen == scen) issue_read(tbl[i].addr, tbl[i].dat);
      drain(nm);
   endtask

   initial begin
      int s;
      // {scenario, logical rd_addr, expected sample}
      tbl = '{'{1, 1023, 1767}, '{1, 0, 744}, '{1, 256, 1000}, '{1, 255, 999}, '{1, 512, 1256},
              '{2, 100, 300}, '{2, 0, 200}, '{2, 1023, 1223}, '{2, 99, 299}, '{2, 101, 301},
              '{3, 0, 5}, '{3, 1023, 1028}, '{3, 1, 6},
              '{4, 1023, 2000}, '{4, 0, 977}, '{4, 512, 1489}, '{4, 46, 1023}};

      // reset state
      do_reset();
      check_stat("reset_status", 0, 0, 0);
      check("reset_rd_valid_oreg0", rd_valid0, 0);
      check("reset_rd_valid_oreg1", rd_valid1, 0);
      check("reset_rd_data_oreg1", rd_data1, 0);
      check("reset_trig_ptr", trig_ptr0, 0);

      // basic capture, pre_depth 256, trigger on sample 1000
      do_arm(256);
      check_stat("s1_armed", 1, 0, 0);
      s = 0;
      while (s < 2000 && !done0) begin
         send(s, s == 1000, 0, 1);
         if (s == 1000) begin
            check_stat("s1_trig", 0, 1, 0);
            check("s1_trig_ptr", trig_ptr0, 1000);
         end
         s++;
      end
      check("s1_done_after_samples", s, 1768);
      check_stat("s1_done", 0, 1, 1);
      apply(1, "s1");

      // early trigger ignored in PRE, wr_valid gaps carrying trig
      do_reset();
      do_arm(100);
      s = 0;
      for (int c = 0; c < 4000 && !done0; c++) begin
         if (c % 2 == 0) begin
            send(s, (s == 50) || (s == 300), 0, 1);
            if (s == 50) check_stat("s2_pre_trig_ignored", 1, 0, 0);
            if (s == 300) check("s2_trig_ptr", trig_ptr0, 300);
            s++;
         end else begin
            send(12'hABC, 1, 0, 0);
         end
      end
      check("s2_done_after_samples", s, 1224);
      apply(2, "s2");

      // pre_depth 0, force_trig on first sample; arm does not cancel an in-flight read
      do_reset();
      do_arm(0);
      check_stat("s3_armed", 1, 0, 0);
      send(5, 0, 1, 1);
      check_stat("s3_forced", 0, 1, 0);
      s = 6;
      while (s < 1100 && !done0) begin
         send(s, 0, 0, 1);
         s++;
      end
      check("s3_done_after_sample", s, 1029);
      apply(3, "s3");
      issue_read(512, 517);
      do_arm(0);
      check_stat("s3_rearmed", 1, 0, 0);
      drain("s3_arm_inflight");

      // maximum pre_depth: trigger sample completes the record
      do_reset();
      do_arm(1023);
      s = 0;
      while (s < 2100 && !triggered0) begin
         send(s, s == 2000, 0, 1);
         s++;
      end
      check("s4_trig_after_samples", s, 2001);
      check_stat("s4_direct_done", 0, 1, 1);
      check("s4_trig_ptr", trig_ptr0, 976);
      apply(4, "s4");
      // rst cancels a read still in the output register
      rd_en = 1'b1; rd_addr = 10'd1023;
      q0.push_back('{2000, cyc + 1});
      tick();
      rd_en = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("s4_rst_cancels_read", rd_valid1, 0);
      check_stat("s4_after_rst", 0, 0, 0);
      check("s4_q0_consumed", q0.size(), 0);

      // arm together with trig, reads in POST, rst mid-POST
      do_reset();
      do_arm(4);
      for (int k = 0; k < 4; k++) send(k, 0, 0, 1);
      arm = 1'b1; pre_depth = 10'd4;
      send(4, 1, 0, 1);
      arm = 1'b0;
      check_stat("s5_arm_beats_trig", 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         send(5 + k, 1, 0, 1);
         check("s5_pre_ignores_trig", triggered0, 0);
      end
      send(8, 0, 0, 1);
      send(9, 1, 0, 1);
      check_stat("s5_post", 0, 1, 0);
      rd_addr = 10'd0;
      for (int k = 0; k < 5; k++) begin
         rd_en = (k < 3);
         send(10 + k, 0, 0, 1);
         check("s5_no_read_in_post_oreg0", rd_valid0, 0);
         check("s5_no_read_in_post_oreg1", rd_valid1, 0);
      end
      rd_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_stat("s5_rst_mid_post", 0, 0, 0);
      check("s5_rst_trig_ptr", trig_ptr0, 0);
      check("s5_rst_rd_valid", rd_valid0, 0);
      send(20, 1, 1, 1);
      check_stat("s5_idle_needs_arm", 0, 0, 0);

      // wrap-around: prior capture leaves wr_ptr at 1000
      do_reset();
      do_arm(0);
      s = 0;
      while (s < 2200 && !done0) begin
         send(s, s == 1000, 0, 1);
         s++;
      end
      check("s6_first_done", s, 2024);
      do_arm(512);
      while (s < 4100 && !done0) begin
         send(s, s == 3272, 0, 1);
         s++;
      end
      check("s6_second_done", s, 3784);
      check("s6_trig_ptr", trig_ptr0, 200);
      check("s6_trig_ptr_oreg1", trig_ptr1, 200);
      for (int i = 0; i < 1024; i++) issue_read(i, 2760 + i);
      drain("s6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
